// File: rtl/led_multicolor_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
//   Shared definitions for the multicolour LED controller.
//   - mode_t     : display mode encoding, also driven out on the mode port
//   - DIR_UP/DN  : chase direction (up = toward the MSB)
//   - next_mode  : OFF -> STEADY -> BLINK -> CHASE -> OFF sequencing
// ---------------------------------------------------------------------------
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_STEADY = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_CHASE  = 2'd3
  } mode_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Mode sequence advanced by each accepted k1 press; wraps back to OFF.
  function automatic mode_t next_mode(input mode_t m);
    mode_t r;
    case (m)
      MODE_OFF:    r = MODE_STEADY;
      MODE_STEADY: r = MODE_BLINK;
      MODE_BLINK:  r = MODE_CHASE;
      MODE_CHASE:  r = MODE_OFF;
      default:     r = MODE_OFF;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/led_multicolor_ctrl_key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
//   Brings one raw, asynchronous, active-high key into the clk domain and
//   filters contact bounce.
//   Path: 2-flop synchroniser -> debouncer. A new level is accepted only
//   after the synchronised key has differed from the accepted level for T0
//   consecutive clocks; any return to the accepted level restarts the count,
//   so glitches shorter than T0 clocks are ignored.
// Ports
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   key_raw  in   raw key level (asynchronous)
//   level    out  debounced key level
//   press    out  one-cycle pulse on an accepted rising level
// ---------------------------------------------------------------------------
module key_debounce #(
  parameter int T0 = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic level,
  output logic press
);

  // Counter only needs to reach T0-1.
  localparam int CW = (T0 > 1) ? $clog2(T0) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(T0 - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          db_reg;
  logic          db_q_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      db_reg    <= 1'b0;
      db_q_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= key_raw;
      sync2_reg <= sync1_reg;
      db_q_reg  <= db_reg;
      if (sync2_reg != db_reg) begin
        // The T0-th consecutive differing clock flips the accepted level.
        if (cnt_reg == CNT_LAST) begin
          db_reg  <= sync2_reg;
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign level = db_reg;
  // db_q_reg is cleared together with db_reg, so reset never yields a pulse.
  assign press = db_reg & ~db_q_reg;

endmodule

// File: rtl/led_multicolor_ctrl.sv
// ---------------------------------------------------------------------------
// led_multicolor_ctrl
//   Two-key LED bank controller with PWM dimming and steady / blink / chase
//   patterns.
//   k1 press : advance mode OFF -> STEADY -> BLINK -> CHASE -> OFF.
//   k2 press : in CHASE reverse chase direction, otherwise step the duty
//              (wrapping from full brightness to dark). A k2 press in the
//              same cycle as a k1 press is discarded.
// Parameters
//   NLED   LED bank width (>=2)
//   T0     debounce length in clocks (>=1)
//   T1     pattern tick period in clocks (>=2)
//   PWM_W  PWM / brightness resolution in bits
// Ports
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   k1    in   raw mode key (asynchronous)
//   k2    in   raw brightness / direction key (asynchronous)
//   led   out  registered LED drive, 1 = lit
//   mode  out  current mode (0 OFF, 1 STEADY, 2 BLINK, 3 CHASE)
// ---------------------------------------------------------------------------
module led_multicolor_ctrl
  import led_pkg::*;
#(
  parameter int NLED  = 4,
  parameter int T0    = 3,
  parameter int T1    = 10,
  parameter int PWM_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            k1,
  input  logic            k2,
  output logic [NLED-1:0] led,
  output logic [1:0]      mode
);

  localparam int              TCW       = $clog2(T1);
  localparam logic [TCW-1:0]  TICK_LAST = TCW'(T1 - 1);
  localparam logic [PWM_W-1:0] DUTY_MAX = '1;
  localparam logic [NLED-1:0] POS_INIT  = NLED'(1);

  // -------------------------------------------------------------------------
  // Key conditioning: index 0 is k1, index 1 is k2.
  // -------------------------------------------------------------------------
  logic [1:0] key_raw;
  logic [1:0] key_press;
  // Only the press pulses drive the control logic; levels stay unused here.
  logic [1:0] key_level_unused;

  assign key_raw = {k2, k1};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_key
      key_debounce #(
        .T0(T0)
      ) u_key_debounce (
        .clk    (clk),
        .rst    (rst),
        .key_raw(key_raw[gi]),
        .level  (key_level_unused[gi]),
        .press  (key_press[gi])
      );
    end
  endgenerate

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  mode_t            mode_reg;
  logic [PWM_W-1:0] duty_reg;
  logic             dir_reg;
  logic [NLED-1:0]  pos_reg;
  logic             phase_reg;
  logic [TCW-1:0]   tick_cnt_reg;
  logic [PWM_W-1:0] pwm_cnt_reg;
  logic [NLED-1:0]  led_reg;

  // -------------------------------------------------------------------------
  // Next-state decode
  // -------------------------------------------------------------------------
  logic             mode_adv;
  logic             k2_act;
  logic             tick;
  logic             pwm_on;
  logic             dir_next;
  logic [PWM_W-1:0] duty_next;
  logic [NLED-1:0]  pos_next;
  logic [NLED-1:0]  pwm_mask;
  logic [NLED-1:0]  led_next;

  assign mode_adv = key_press[0];
  // k1 wins a simultaneous press; the k2 press is simply lost.
  assign k2_act   = key_press[1] & ~key_press[0];
  assign tick     = (tick_cnt_reg == TICK_LAST);
  // Full duty is forced on because pwm_cnt never exceeds MAX.
  assign pwm_on   = (duty_reg == DUTY_MAX) || (pwm_cnt_reg < duty_reg);
  assign pwm_mask = {NLED{pwm_on}};

  always_comb begin
    dir_next  = dir_reg;
    duty_next = duty_reg;
    if (k2_act) begin
      if (mode_reg == MODE_CHASE) begin
        dir_next = ~dir_reg;
      end else begin
        duty_next = duty_reg + 1'b1;
      end
    end
  end

  // The rotation follows dir_next so a reversal on a tick cycle takes
  // effect on that same step.
  always_comb begin
    pos_next = pos_reg;
    if (dir_next == DIR_UP) begin
      pos_next = {pos_reg[NLED-2:0], pos_reg[NLED-1]};
    end else begin
      pos_next = {pos_reg[0], pos_reg[NLED-1:1]};
    end
  end

  always_comb begin
    led_next = '0;
    case (mode_reg)
      MODE_OFF:    led_next = '0;
      MODE_STEADY: led_next = pwm_mask;
      MODE_BLINK:  led_next = phase_reg ? pwm_mask : '0;
      MODE_CHASE:  led_next = pos_reg & pwm_mask;
      default:     led_next = '0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Mode FSM, pattern timing and output register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_reg     <= MODE_OFF;
      duty_reg     <= DUTY_MAX;
      dir_reg      <= DIR_UP;
      pos_reg      <= POS_INIT;
      phase_reg    <= 1'b1;
      tick_cnt_reg <= '0;
      pwm_cnt_reg  <= '0;
      led_reg      <= '0;
    end else begin
      pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
      led_reg     <= led_next;
      duty_reg    <= duty_next;
      dir_reg     <= dir_next;
      if (mode_adv) begin
        // Every mode starts its pattern from a clean tick boundary.
        mode_reg     <= next_mode(mode_reg);
        tick_cnt_reg <= '0;
        phase_reg    <= 1'b1;
        pos_reg      <= POS_INIT;
      end else begin
        if (tick) begin
          tick_cnt_reg <= '0;
          phase_reg    <= ~phase_reg;
          pos_reg      <= pos_next;
        end else begin
          tick_cnt_reg <= tick_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign led  = led_reg;
  assign mode = mode_reg;

endmodule

// File: tb/tb_led_multicolor_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_multicolor_ctrl
//   Scoreboard bench. A reference model steps once per clock edge, works out
//   what mode and led must read after that edge and queues it; a monitor on
//   the falling edge pops each entry and compares it with the DUT outputs.
//   The model reasons in terms of windows of synchronised key samples, time
//   since reset / mode entry, and an integer chase index.
// ---------------------------------------------------------------------------
module tb_led_multicolor_ctrl;

  localparam int NLED  = 4;
  localparam int T0    = 3;
  localparam int T1    = 10;
  localparam int PWM_W = 4;
  localparam int DMAX  = (1 << PWM_W) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            k1  = 1'b0;
  logic            k2  = 1'b0;
  logic [NLED-1:0] led;
  logic [1:0]      mode;

  led_multicolor_ctrl #(
    .NLED (NLED),
    .T0   (T0),
    .T1   (T1),
    .PWM_W(PWM_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .k1  (k1),
    .k2  (k2),
    .led (led),
    .mode(mode)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]      mode;
    logic [NLED-1:0] led;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // ---------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------
  bit          m_valid = 1'b0;
  int          m_mode  = 0;
  int          m_duty  = DMAX;
  int          m_dir   = 0;      // 0 = toward MSB
  int          m_pos   = 0;      // index of the lit chase bit
  int          m_age   = 0;      // clocks since reset -> PWM phase
  int          m_since = 0;      // clocks since mode entry -> tick phase
  logic [15:0] m_hist [2];       // raw samples, [0] = newest
  bit          m_db   [2];
  bit          m_pend [2];       // accepted press, acted on next edge

  always @(posedge clk) begin
    exp_t            e;
    logic [1:0]      raw;
    logic [NLED-1:0] full;
    bit              on;
    bit              ntick;
    bit              acc;
    int              pwm;
    raw = {k2, k1};
    e   = '0;
    if (rst) begin
      m_valid = 1'b1;
      m_mode  = 0;
      m_duty  = DMAX;
      m_dir   = 0;
      m_pos   = 0;
      m_age   = 0;
      m_since = 0;
      for (int k = 0; k < 2; k++) begin
        m_hist[k] = '0;
        m_db[k]   = 1'b0;
        m_pend[k] = 1'b0;
      end
      e.mode = 2'd0;
      e.led  = '0;
    end else if (m_valid) begin
      // LED reflects the state held before this edge.
      pwm  = m_age % (DMAX + 1);
      on   = (m_duty == DMAX) || (pwm < m_duty);
      full = on ? '1 : '0;
      case (m_mode)
        1:       e.led = full;
        2:       e.led = (((m_since / T1) % 2) == 0) ? full : '0;
        3:       e.led = full & (NLED'(1) << m_pos);
        default: e.led = '0;
      endcase
      ntick = ((m_since % T1) == T1 - 1);
      if (m_pend[0]) begin
        m_mode  = (m_mode + 1) % 4;
        m_since = 0;
        m_pos   = 0;
      end else begin
        if (m_pend[1]) begin
          if (m_mode == 3) m_dir = 1 - m_dir;
          else             m_duty = (m_duty + 1) % (DMAX + 1);
        end
        if (ntick) m_pos = (m_dir == 0) ? (m_pos + 1) % NLED : (m_pos + NLED - 1) % NLED;
        m_since++;
      end
      m_age++;
      // A level is accepted once the last T0 synchronised samples (raw delayed
      // by two clocks) all disagree with the current accepted level.
      for (int k = 0; k < 2; k++) begin
        acc = 1'b1;
        for (int j = 1; j <= T0; j++) if (m_hist[k][j] == m_db[k]) acc = 1'b0;
        m_pend[k] = 1'b0;
        if (acc) begin
          m_db[k]   = !m_db[k];
          m_pend[k] = m_db[k];
        end
        m_hist[k] = {m_hist[k][14:0], raw[k]};
      end
      e.mode = 2'(m_mode);
    end
    if (m_valid) exp_q.push_back(e);
  end

  // ---------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (mode !== e.mode) begin
        failures++;
        $display("FAIL mode t=%0t got=%0d expected=%0d", $time, mode, e.mode);
      end
      checks++;
      if (led !== e.led) begin
        failures++;
        $display("FAIL led t=%0t got=%b expected=%b (mode=%0d)", $time, led, e.led, e.mode);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  int txn = 0;

  task automatic drive(input bit a, input bit b, input bit r);
    @(posedge clk);
    #2;
    k1  = a;
    k2  = b;
    rst = r;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic keys(input bit a, input bit b, input int hold, input int gap);
    $display("txn %0d: k1=%0d k2=%0d hold=%0d gap=%0d model_mode=%0d duty=%0d dir=%0d",
             txn, a, b, hold, gap, m_mode, m_duty, m_dir);
    txn++;
    repeat (hold) drive(a, b, 1'b0);
    idle(gap);
  endtask

  initial begin
    // Reset for two edges, then idle.
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    idle(50);
    // Short bounce is ignored; a long press enters STEADY.
    keys(1'b1, 1'b0, 1, 20);
    keys(1'b1, 1'b0, 2, 20);
    keys(1'b1, 1'b0, 8, 30);
    // BLINK, then CHASE with a full lap.
    keys(1'b1, 1'b0, 8, 45);
    keys(1'b1, 1'b0, 8, 60);
    // Reverse the chase, then simultaneous press -> OFF.
    keys(1'b0, 1'b1, 8, 35);
    keys(1'b1, 1'b1, 8, 20);
    // STEADY: duty MAX -> 0, then up to 8.
    keys(1'b1, 1'b0, 8, 30);
    keys(1'b0, 1'b1, 8, 30);
    for (int i = 0; i < 8; i++) keys(1'b0, 1'b1, 6, 8);
    idle(40);
    // Into CHASE, then reset while a k1 debounce is in progress.
    keys(1'b1, 1'b0, 8, 15);
    keys(1'b1, 1'b0, 8, 25);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    idle(30);
    // Randomised traffic, including occasional resets.
    for (int i = 0; i < 260; i++) begin
      int kind;
      int hold;
      int gap;
      kind = $urandom_range(0, 19);
      hold = $urandom_range(1, 9);
      gap  = $urandom_range(0, 45);
      if (kind < 8)       keys(1'b1, 1'b0, hold, gap);
      else if (kind < 16) keys(1'b0, 1'b1, hold, gap);
      else if (kind < 19) keys(1'b1, 1'b1, hold, gap);
      else begin
        $display("txn %0d: reset hold=%0d gap=%0d", txn, hold % 3 + 1, gap);
        txn++;
        repeat (hold % 3 + 1) drive(1'b0, 1'b0, 1'b1);
        idle(gap);
      end
    end
    idle(5);
    @(negedge clk);
    #1;
    // The scoreboard must have been exercised over the whole run.
    checks++;
    if (checks < 2000) begin
      failures++;
      $display("FAIL coverage got=%0d comparisons required>=2000", checks);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
